// File: rtl/coin_pkg.sv
// Shared types and constants for the coin dispenser slice.
// Coin values are expressed in nickel units.
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    COIN,
    WAIT,
    DONE
  } state_t;

  localparam int COIN_NICKEL = 1;
  localparam int COIN_DIME   = 2;

endpackage

// File: rtl/coin_planner.sv
// Greedy payout planner: dimes first, nickels for the rest.
// Ports: amount/dimes/nickels in; d, n coin counts and feasible out.
module coin_planner
  import coin_pkg::*;
#(
  parameter int AMT_W = 5,
  parameter int INV_W = 6
) (
  input  logic [AMT_W-1:0] amount,
  input  logic [INV_W-1:0] dimes,
  input  logic [INV_W-1:0] nickels,
  output logic [AMT_W:0]   d,
  output logic [AMT_W:0]   n,
  output logic             feasible
);

  localparam int CW = AMT_W + 1;
  localparam int WW = (INV_W > CW) ? INV_W : CW;

  logic [WW-1:0] amt;
  logic [WW-1:0] half;
  logic [WW-1:0] dim;
  logic [WW-1:0] nic;
  logic [WW-1:0] dsel;
  logic [WW-1:0] rest;

  always_comb begin
    amt      = WW'(amount);
    dim      = WW'(dimes);
    nic      = WW'(nickels);
    half     = amt / WW'(COIN_DIME);
    dsel     = (half < dim) ? half : dim;
    // dsel*2 never exceeds amt, so rest is non-negative
    rest     = amt - WW'(COIN_DIME) * dsel;
    feasible = (rest <= nic);
    d        = CW'(dsel);
    n        = CW'(rest);
  end

endmodule

// File: rtl/coin_dispenser.sv
// Coin dispenser: pays a nickel-unit amount as a train of dime/nickel
// pulses from on-board inventory; infeasible payouts are refused whole.
// Ports: clk, reset; io_req_* request handshake; io_refill reload;
// io_dime/io_nickel coin pulses; io_done/io_error completion;
// io_dimes_left/io_nickels_left inventory.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W     = 5,
  parameter int INV_W     = 6,
  parameter int GAP       = 1,
  parameter int DIME_INIT = 8,
  parameter int NICK_INIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_req_valid,
  input  logic [AMT_W-1:0] io_req_amount,
  output logic             io_req_ready,
  input  logic             io_refill,
  output logic             io_dime,
  output logic             io_nickel,
  output logic             io_done,
  output logic             io_error,
  output logic [INV_W-1:0] io_dimes_left,
  output logic [INV_W-1:0] io_nickels_left
);

  localparam int CW = AMT_W + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state;
  logic             idle_q;
  logic [AMT_W-1:0] amt_q;
  logic [CW-1:0]    d_cnt;
  logic [CW-1:0]    n_cnt;
  logic [GW-1:0]    gap_cnt;

  logic [CW-1:0]    plan_d;
  logic [CW-1:0]    plan_n;
  logic             plan_ok;

  logic [CW-1:0]    src_d;
  logic [CW-1:0]    src_n;
  logic [CW-1:0]    nxt_d;
  logic [CW-1:0]    nxt_n;
  logic             pick_dime;
  logic             more;
  logic             emit;

  coin_planner #(
    .AMT_W (AMT_W),
    .INV_W (INV_W)
  ) u_planner (
    .amount   (amt_q),
    .dimes    (io_dimes_left),
    .nickels  (io_nickels_left),
    .d        (plan_d),
    .n        (plan_n),
    .feasible (plan_ok)
  );

  // refill in IDLE takes priority over a request
  assign io_req_ready = idle_q & ~io_refill;

  assign more = (d_cnt != '0) || (n_cnt != '0);

  always_comb begin
    src_d     = (state == PLAN) ? plan_d : d_cnt;
    src_n     = (state == PLAN) ? plan_n : n_cnt;
    pick_dime = (src_d != '0);
    nxt_d     = pick_dime ? src_d - 1'b1 : src_d;
    nxt_n     = pick_dime ? src_n : src_n - 1'b1;
    emit      = 1'b0;
    unique case (state)
      PLAN:    emit = plan_ok && (amt_q != '0);
      COIN:    emit = more && (GAP == 0);
      WAIT:    emit = (gap_cnt == '0);
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idle_q          <= 1'b1;
      amt_q           <= '0;
      d_cnt           <= '0;
      n_cnt           <= '0;
      gap_cnt         <= '0;
      io_dime         <= 1'b0;
      io_nickel       <= 1'b0;
      io_done         <= 1'b0;
      io_error        <= 1'b0;
      io_dimes_left   <= INV_W'(DIME_INIT);
      io_nickels_left <= INV_W'(NICK_INIT);
    end else begin
      io_dime   <= 1'b0;
      io_nickel <= 1'b0;
      io_done   <= 1'b0;
      io_error  <= 1'b0;

      // pulse and inventory change land in the same cycle
      if (emit) begin
        io_dime   <= pick_dime;
        io_nickel <= ~pick_dime;
        d_cnt     <= nxt_d;
        n_cnt     <= nxt_n;
        if (pick_dime)
          io_dimes_left <= io_dimes_left - 1'b1;
        else
          io_nickels_left <= io_nickels_left - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (io_refill) begin
            io_dimes_left   <= INV_W'(DIME_INIT);
            io_nickels_left <= INV_W'(NICK_INIT);
          end else if (io_req_valid) begin
            amt_q  <= io_req_amount;
            state  <= PLAN;
            idle_q <= 1'b0;
          end
        end
        PLAN: begin
          if (!plan_ok) begin
            state    <= DONE;
            io_done  <= 1'b1;
            io_error <= 1'b1;
          end else if (amt_q == '0) begin
            state   <= DONE;
            io_done <= 1'b1;
          end else begin
            state <= COIN;
          end
        end
        COIN: begin
          if (!more) begin
            state   <= DONE;
            io_done <= 1'b1;
          end else if (GAP == 0) begin
            state <= COIN;
          end else begin
            state   <= WAIT;
            gap_cnt <= GW'(GAP - 1);
          end
        end
        WAIT: begin
          if (gap_cnt == '0)
            state <= COIN;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: three instances with
// different inventories, a schedule-based model and literal checks.
module tb_coin_dispenser;

  localparam int GAP = 1;
  localparam int DINIT [3] = '{8, 0, 1};
  localparam int NINIT [3] = '{8, 8, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       valid  [3];
  logic [4:0] amount [3];
  logic       refill [3];
  logic       ready  [3];
  logic       dime   [3];
  logic       nick   [3];
  logic       done   [3];
  logic       err    [3];
  logic [5:0] dl     [3];
  logic [5:0] nl     [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state
  bit model_on = 1'b0;
  bit busy  [3];
  bit okf   [3];
  int t0    [3];
  int pd    [3];
  int pn    [3];
  int nc    [3];
  int dcyc  [3];
  int inv_d [3];
  int inv_n [3];
  bit e_dime [3];
  bit e_nick [3];
  bit e_done [3];
  bit e_err  [3];

  always #5 clk = ~clk;

  coin_dispenser #(.GAP(GAP), .DIME_INIT(8), .NICK_INIT(8)) u0 (
    .clk(clk), .reset(reset),
    .io_req_valid(valid[0]), .io_req_amount(amount[0]),
    .io_req_ready(ready[0]), .io_refill(refill[0]),
    .io_dime(dime[0]), .io_nickel(nick[0]),
    .io_done(done[0]), .io_error(err[0]),
    .io_dimes_left(dl[0]), .io_nickels_left(nl[0])
  );

  coin_dispenser #(.GAP(GAP), .DIME_INIT(0), .NICK_INIT(8)) u1 (
    .clk(clk), .reset(reset),
    .io_req_valid(valid[1]), .io_req_amount(amount[1]),
    .io_req_ready(ready[1]), .io_refill(refill[1]),
    .io_dime(dime[1]), .io_nickel(nick[1]),
    .io_done(done[1]), .io_error(err[1]),
    .io_dimes_left(dl[1]), .io_nickels_left(nl[1])
  );

  coin_dispenser #(.GAP(GAP), .DIME_INIT(1), .NICK_INIT(0)) u2 (
    .clk(clk), .reset(reset),
    .io_req_valid(valid[2]), .io_req_amount(amount[2]),
    .io_req_ready(ready[2]), .io_refill(refill[2]),
    .io_dime(dime[2]), .io_nickel(nick[2]),
    .io_done(done[2]), .io_error(err[2]),
    .io_dimes_left(dl[2]), .io_nickels_left(nl[2])
  );

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: on acceptance, plan greedily and derive the whole schedule
  // of coin and done cycles from the accept cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        busy[i]  = 1'b0;
        inv_d[i] = DINIT[i];
        inv_n[i] = NINIT[i];
      end else if (!busy[i]) begin
        if (refill[i]) begin
          inv_d[i] = DINIT[i];
          inv_n[i] = NINIT[i];
        end else if (valid[i]) begin
          int a;
          int h;
          a       = int'(amount[i]);
          h       = a / 2;
          busy[i] = 1'b1;
          t0[i]   = cyc;
          pd[i]   = (h < inv_d[i]) ? h : inv_d[i];
          pn[i]   = a - 2 * pd[i];
          okf[i]  = (pn[i] <= inv_n[i]);
          nc[i]   = pd[i] + pn[i];
          if (!okf[i] || nc[i] == 0)
            dcyc[i] = cyc + 2;
          else
            dcyc[i] = cyc + 2 + (nc[i] - 1) * (GAP + 1) + 1;
        end
      end else if (cyc == dcyc[i]) begin
        busy[i] = 1'b0;
      end
    end
    if (reset) model_on = 1'b1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      e_dime[i] = 1'b0;
      e_nick[i] = 1'b0;
      e_done[i] = 1'b0;
      e_err[i]  = 1'b0;
      if (busy[i]) begin
        int rel;
        rel = cyc - t0[i] - 2;
        if (cyc == dcyc[i]) begin
          e_done[i] = 1'b1;
          e_err[i]  = !okf[i];
        end else if (okf[i] && rel >= 0 && (rel % (GAP + 1)) == 0) begin
          int k;
          k = rel / (GAP + 1);
          if (k < nc[i]) begin
            if (k < pd[i]) begin
              e_dime[i] = 1'b1;
              inv_d[i]--;
            end else begin
              e_nick[i] = 1'b1;
              inv_n[i]--;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d dime", i), int'(dime[i]), int'(e_dime[i]));
        check($sformatf("u%0d nickel", i), int'(nick[i]), int'(e_nick[i]));
        check($sformatf("u%0d done", i), int'(done[i]), int'(e_done[i]));
        check($sformatf("u%0d error", i), int'(err[i]), int'(e_err[i]));
        check($sformatf("u%0d dimes_left", i), int'(dl[i]), inv_d[i]);
        check($sformatf("u%0d nickels_left", i), int'(nl[i]), inv_n[i]);
        check($sformatf("u%0d ready", i), int'(ready[i]),
              int'(!busy[i] && !refill[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // leaves the bench one cycle after the accept cycle T
  task automatic send(input int i, input int a);
    valid[i]  = 1'b1;
    amount[i] = 5'(a);
    tick(1);
    valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int k;
    k = 0;
    while (!ready[i] && k < 100) begin
      tick(1);
      k++;
    end
    check($sformatf("u%0d idle wait", i), int'(ready[i]), 1);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i]  = 1'b0;
      amount[i] = '0;
      refill[i] = 1'b0;
    end
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset ready u0", int'(ready[0]), 1);
    check("reset dimes u0", int'(dl[0]), 8);
    check("reset dimes u1", int'(dl[1]), 0);
    check("reset nickels u2", int'(nl[2]), 0);
    check("reset done u0", int'(done[0]), 0);

    // amount=4: dimes at T+2, T+4, done at T+5
    send(0, 4);
    tick(1);
    check("a4 dime T+2", int'(dime[0]), 1);
    tick(1);
    check("a4 gap T+3", int'(dime[0]), 0);
    tick(1);
    check("a4 dime T+4", int'(dime[0]), 1);
    check("a4 dimes_left", int'(dl[0]), 6);
    tick(1);
    check("a4 done T+5", int'(done[0]), 1);
    check("a4 error T+5", int'(err[0]), 0);
    wait_idle(0);

    // refill together with valid: refill wins, no request taken
    valid[0]  = 1'b1;
    amount[0] = 5'd2;
    refill[0] = 1'b1;
    #1;
    check("refill ready low", int'(ready[0]), 0);
    tick(1);
    valid[0]  = 1'b0;
    refill[0] = 1'b0;
    #1;
    check("refill not accepted", int'(ready[0]), 1);
    check("refill dimes", int'(dl[0]), 8);
    check("refill nickels", int'(nl[0]), 8);

    // amount=3: dime T+2, nickel T+4, done T+5
    send(0, 3);
    tick(1);
    check("a3 dime T+2", int'(dime[0]), 1);
    tick(2);
    check("a3 nickel T+4", int'(nick[0]), 1);
    check("a3 no dime T+4", int'(dime[0]), 0);
    tick(1);
    check("a3 done T+5", int'(done[0]), 1);
    check("a3 dimes_left", int'(dl[0]), 7);
    check("a3 nickels_left", int'(nl[0]), 7);
    wait_idle(0);

    // no dimes: three nickels, done at T+7
    send(1, 3);
    tick(1);
    check("nd nickel T+2", int'(nick[1]), 1);
    tick(2);
    check("nd nickel T+4", int'(nick[1]), 1);
    tick(2);
    check("nd nickel T+6", int'(nick[1]), 1);
    tick(1);
    check("nd done T+7", int'(done[1]), 1);
    check("nd nickels_left", int'(nl[1]), 5);
    wait_idle(1);

    // infeasible: done+error at T+2, inventory untouched
    send(2, 3);
    tick(1);
    check("inf done T+2", int'(done[2]), 1);
    check("inf error T+2", int'(err[2]), 1);
    check("inf dimes_left", int'(dl[2]), 1);
    check("inf nickels_left", int'(nl[2]), 0);
    wait_idle(2);

    // zero amount
    send(0, 0);
    tick(1);
    check("zero done T+2", int'(done[0]), 1);
    check("zero error T+2", int'(err[0]), 0);
    check("zero no nickel", int'(nick[0]), 0);
    wait_idle(0);

    // reset mid-payout at T+3
    send(0, 4);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    check("abort no dime T+4", int'(dime[0]), 0);
    check("abort ready T+4", int'(ready[0]), 1);
    check("abort dimes", int'(dl[0]), 8);
    check("abort nickels", int'(nl[0]), 8);
    tick(1);
    check("abort no done T+5", int'(done[0]), 0);

    // held valid is taken again once back in IDLE
    valid[0]  = 1'b1;
    amount[0] = 5'd1;
    tick(12);
    valid[0] = 1'b0;
    wait_idle(0);

    // boundaries: too large, exactly drain, then empty
    refill[0] = 1'b1;
    tick(1);
    refill[0] = 1'b0;
    send(0, 31);
    tick(1);
    check("a31 error", int'(err[0]), 1);
    wait_idle(0);
    send(0, 24);
    wait_idle(0);
    check("drain dimes", int'(dl[0]), 0);
    check("drain nickels", int'(nl[0]), 0);
    send(0, 1);
    tick(1);
    check("empty error", int'(err[0]), 1);
    wait_idle(0);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
